// File: rtl/regfile_pkg.sv
// Shared constants and types for the LEGv8 decode-stage register file.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NREGS    = 32;
    localparam int ZERO_REG = 31;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/mux_32_1.sv
// Single-bit 32:1 multiplexer slice; one slice per data bit per read port.
module mux_32_1
    import regfile_pkg::*;
(
    input  logic [NREGS-1:0] d_i,
    input  reg_idx_t         sel_i,
    output logic             y_o
);

    logic [15:0] lvl1;
    logic [7:0]  lvl2;
    logic [3:0]  lvl3;
    logic [1:0]  lvl4;

    // Balanced 2:1 tree, low select bit resolved first.
    always_comb begin
        lvl1 = '0;
        lvl2 = '0;
        lvl3 = '0;
        lvl4 = '0;
        for (int i = 0; i < 16; i++) begin
            lvl1[i] = sel_i[0] ? d_i[2*i+1] : d_i[2*i];
        end
        for (int i = 0; i < 8; i++) begin
            lvl2[i] = sel_i[1] ? lvl1[2*i+1] : lvl1[2*i];
        end
        for (int i = 0; i < 4; i++) begin
            lvl3[i] = sel_i[2] ? lvl2[2*i+1] : lvl2[2*i];
        end
        for (int i = 0; i < 2; i++) begin
            lvl4[i] = sel_i[3] ? lvl3[2*i+1] : lvl3[2*i];
        end
        y_o = sel_i[4] ? lvl4[1] : lvl4[0];
    end

endmodule

// File: rtl/reg_64.sv
// One general-purpose register: loads d_i on a rising clk when en_i is high,
// clears asynchronously on reset.
module reg_64 #(
    parameter int W = regfile_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next state: load new data when enabled, otherwise hold.
    always_comb begin
        data_d = en_i ? d_i : data_q;
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/reg_file_bypass.sv
// 32 x 64-bit LEGv8 register file: two combinational read ports, one
// synchronous write port, optional same-cycle write-to-read forwarding.
// X31 (XZR) is not stored: it reads zero and swallows writes.
// The read path is built from 32:1 bit slices, so ADDR_W must stay 5.
module reg_file_bypass #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    // Per-register write enables (one-hot or all zero).
    logic [NREGS-1:0]             wr_en;
    // Register contents, indexed [register][bit].
    logic [NREGS-1:0][DATA_W-1:0] reg_q;
    // Same contents transposed to [bit][register] for the bit-slice muxes.
    logic [DATA_W-1:0][NREGS-1:0] col;
    // Raw mux-bank outputs before the bypass/zero stage.
    logic [DATA_W-1:0]            mux1;
    logic [DATA_W-1:0]            mux2;
    logic                         byp1;
    logic                         byp2;

    // 5:32 decoder gated by RegWrite; XZR never enabled, nothing written in reset.
    // A gated-off RegWrite forces every enable low regardless of WriteRegister.
    always_comb begin
        wr_en = '0;
        for (int r = 0; r < NREGS; r++) begin
            wr_en[r] = RegWrite && !reset && (r != ZERO_REG) &&
                       (WriteRegister == ADDR_W'(r));
        end
    end

    // One register instance per general register; XZR is a constant zero.
    for (genvar r = 0; r < NREGS; r++) begin : g_regs
        if (r == ZERO_REG) begin : g_zero
            assign reg_q[r] = '0;
        end else begin : g_reg
            reg_64 #(
                .W (DATA_W)
            ) u_reg (
                .clk   (clk),
                .reset (reset),
                .en_i  (wr_en[r]),
                .d_i   (WriteData),
                .q_o   (reg_q[r])
            );
        end
    end

    // Regroup register bits so each mux slice sees one bit of every register.
    always_comb begin
        col = '0;
        for (int b = 0; b < DATA_W; b++) begin
            for (int r = 0; r < NREGS; r++) begin
                col[b][r] = reg_q[r][b];
            end
        end
    end

    // Two banks of 32:1 bit slices, one per read port.
    for (genvar b = 0; b < DATA_W; b++) begin : g_bits
        mux_32_1 u_mux1 (
            .d_i   (col[b]),
            .sel_i (ReadRegister1),
            .y_o   (mux1[b])
        );
        mux_32_1 u_mux2 (
            .d_i   (col[b]),
            .sel_i (ReadRegister2),
            .y_o   (mux2[b])
        );
    end

    // Forwarding condition per port; suppressed in reset and for XZR.
    always_comb begin
        byp1 = (BYPASS != 0) && RegWrite && !reset &&
               (WriteRegister != ZERO_IDX) && (WriteRegister == ReadRegister1);
        byp2 = (BYPASS != 0) && RegWrite && !reset &&
               (WriteRegister != ZERO_IDX) && (WriteRegister == ReadRegister2);
    end

    // Final 2:1 bypass stage; XZR reads force zero whatever else is going on.
    always_comb begin
        if (ReadRegister1 == ZERO_IDX) begin
            ReadData1 = '0;
        end else if (byp1) begin
            ReadData1 = WriteData;
        end else begin
            ReadData1 = mux1;
        end

        if (ReadRegister2 == ZERO_IDX) begin
            ReadData2 = '0;
        end else if (byp2) begin
            ReadData2 = WriteData;
        end else begin
            ReadData2 = mux2;
        end
    end

endmodule

// File: tb/tb_reg_file_bypass.sv
// Directed bench for reg_file_bypass: a forwarding instance and a
// non-forwarding instance share all inputs.
module tb_reg_file_bypass;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [63:0] write_data;
  logic [4:0]  read_register1;
  logic [4:0]  read_register2;
  logic [63:0] rd1_byp, rd2_byp;
  logic [63:0] rd1_nob, rd2_nob;

  // Reference contents, updated only from the values the bench writes.
  logic [63:0] mdl [32];

  int n_tests;
  int n_fail;

  reg_file_bypass #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(1)) u_dut_byp (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (reg_write),
    .WriteRegister (write_register),
    .WriteData     (write_data),
    .ReadRegister1 (read_register1),
    .ReadRegister2 (read_register2),
    .ReadData1     (rd1_byp),
    .ReadData2     (rd2_byp)
  );

  reg_file_bypass #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(0)) u_dut_nob (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (reg_write),
    .WriteRegister (write_register),
    .WriteData     (write_data),
    .ReadRegister1 (read_register1),
    .ReadRegister2 (read_register2),
    .ReadData1     (rd1_nob),
    .ReadData2     (rd2_nob)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
  endtask

  // One write cycle; returns 1 time unit after the capturing edge.
  task automatic do_write(input logic [4:0] idx, input logic [63:0] data);
    reg_write      = 1'b1;
    write_register = idx;
    write_data     = data;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    if (idx != 5'd31) mdl[idx] = data;
  endtask

  // Read a pair of indices on both instances, compare with the model.
  task automatic read_pair(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    read_register1 = r1;
    read_register2 = r2;
    #1;
    check({tag, "_b1"}, rd1_byp, mdl[r1]);
    check({tag, "_b2"}, rd2_byp, mdl[r2]);
    check({tag, "_n1"}, rd1_nob, mdl[r1]);
    check({tag, "_n2"}, rd2_nob, mdl[r2]);
  endtask

  // Read every index on both ports expecting zero.
  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      read_register1 = 5'(i);
      read_register2 = 5'(31 - i);
      #1;
      check({tag, "_b1"}, rd1_byp, 64'h0);
      check({tag, "_b2"}, rd2_byp, 64'h0);
      check({tag, "_n1"}, rd1_nob, 64'h0);
      check({tag, "_n2"}, rd2_nob, 64'h0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset          = 1'b1;
    reg_write      = 1'b0;
    write_register = 5'd0;
    write_data     = 64'h0;
    read_register1 = 5'd0;
    read_register2 = 5'd0;
    clear_model();

    // Reset state, then release with no writes.
    repeat (2) @(posedge clk);
    #1;
    read_all_zero("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    read_all_zero("rst_rel");

    // Basic write.
    do_write(5'd5, 64'hDEAD_BEEF_CAFE_F00D);
    read_register1 = 5'd5;
    read_register2 = 5'd6;
    #1;
    check("wr5_rd1", rd1_byp, 64'hDEAD_BEEF_CAFE_F00D);
    check("wr5_rd6", rd2_byp, 64'h0);
    check("wr5_rd1_nob", rd1_nob, 64'hDEAD_BEEF_CAFE_F00D);

    // RegWrite low: nothing changes even with a live address/data.
    reg_write      = 1'b0;
    write_register = 5'd5;
    write_data     = 64'h5555_5555_5555_5555;
    @(posedge clk);
    #1;
    read_pair("hold5", 5'd5, 5'd6);

    // XZR: write discarded, reads zero, others untouched.
    do_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    read_register1 = 5'd31;
    read_register2 = 5'd31;
    #1;
    check("xzr_rd1", rd1_byp, 64'h0);
    check("xzr_rd2", rd2_byp, 64'h0);
    for (int i = 0; i < 31; i++) read_pair("xzr_others", 5'(i), 5'(30 - i));

    // Same-cycle forwarding on both ports.
    reg_write      = 1'b1;
    write_register = 5'd7;
    write_data     = 64'h1234;
    read_register1 = 5'd7;
    read_register2 = 5'd7;
    #1;
    check("byp_rd1", rd1_byp, 64'h1234);
    check("byp_rd2", rd2_byp, 64'h1234);
    check("nob_old1", rd1_nob, 64'h0);
    check("nob_old2", rd2_nob, 64'h0);
    read_register2 = 5'd5;
    #1;
    check("byp_only1", rd2_byp, 64'hDEAD_BEEF_CAFE_F00D);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    mdl[7] = 64'h1234;
    read_register2 = 5'd7;
    #1;
    check("nob_new1", rd1_nob, 64'h1234);
    check("nob_new2", rd2_nob, 64'h1234);
    check("byp_after", rd1_byp, 64'h1234);

    // Forwarding never applies to XZR.
    reg_write      = 1'b1;
    write_register = 5'd31;
    write_data     = 64'hAAAA_AAAA_AAAA_AAAA;
    read_register1 = 5'd31;
    read_register2 = 5'd31;
    #1;
    check("byp_xzr1", rd1_byp, 64'h0);
    check("byp_xzr2", rd2_byp, 64'h0);
    @(posedge clk);
    #1;
    reg_write = 1'b0;

    // Reset mid-operation.
    for (int i = 1; i <= 30; i++) do_write(5'(i), 64'(i) * 64'h111);
    read_pair("pre_rst_a", 5'd3, 5'd30);
    read_pair("pre_rst_b", 5'd1, 5'd17);
    reg_write      = 1'b1;
    write_register = 5'd3;
    write_data     = 64'hABC;
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    #1;
    read_register1 = 5'd3;
    read_register2 = 5'd3;
    #1;
    check("rst_byp_sup1", rd1_byp, 64'h0);
    check("rst_byp_sup2", rd2_byp, 64'h0);
    read_all_zero("rst_async");
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    read_all_zero("rst_after");

    // Walking ones.
    for (int i = 0; i <= 30; i++) do_write(5'(i), 64'h1 << i);
    for (int i = 0; i <= 30; i++) begin
      read_register1 = 5'(i);
      read_register2 = 5'(30 - i);
      #1;
      check("walk_b1", rd1_byp, 64'h1 << i);
      check("walk_b2", rd2_byp, 64'h1 << (30 - i));
      check("walk_n1", rd1_nob, 64'h1 << i);
      check("walk_n2", rd2_nob, 64'h1 << (30 - i));
    end
    read_register1 = 5'd31;
    read_register2 = 5'd31;
    #1;
    check("walk_xzr1", rd1_byp, 64'h0);
    check("walk_xzr2", rd2_nob, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
